stage_sequencer: RTL
====================

Name: stage_sequencer

Overview:
Single-clock, parametrised stage sequencer that replaces per-stage derived clocks with one-hot stage enables. It drives the IF/ID/EX/MEM/WB stage blocks in the core top level. It supports free-run and single-step modes, flush, and per-stage completion handshakes for multi-cycle stages such as memory fetch or access. It also provides a watchdog timeout and a retired-instruction counter.

Parameters:
NUM_STAGES, 5, number of sequenced stages (legal range 2..16); stage 0 is fetch, stage NUM_STAGES-1 is writeback.
WAIT_MASK, 5'b01001, one bit per stage; 1 = stage waits for i_stage_done[k] after its enable pulse (default: IF and MEM wait).
TIMEOUT, 16, maximum cycles spent in WAIT before error (legal range >=2).
CNT_W, 32, width of the retired-instruction counter.

Ports:
i_clk  input  1  single clock; all logic on rising edge.
i_reset  input  1  synchronous, active-high reset.
i_run  input  1  level; 1 = free-run instructions back-to-back.
i_step  input  1  pulse; execute exactly one instruction from IDLE.
i_flush  input  1  pulse; abort current instruction and restart at stage 0.
i_stage_done  input  NUM_STAGES  per-stage completion; bit k is sampled only while in WAIT for stage k.
i_clear_err  input  1  pulse; leave ERROR and return to IDLE.
o_stage_en  output  NUM_STAGES  one-hot stage enable, one cycle per stage visit.
o_stage_idx  output  $clog2(NUM_STAGES)  current stage index.
o_wait  output  1  sequencer is in WAIT.
o_busy  output  1  not IDLE and not ERROR.
o_retire  output  1  one-cycle pulse when an instruction completes its last stage.
o_retire_cnt  output  CNT_W  count of retired instructions.
o_error  output  1  sticky watchdog timeout flag.

Behaviour:
- Reset (synchronous, i_reset=1 at an edge):
  - State is IDLE.
  - o_stage_en=0, o_stage_idx=0, o_wait=0, o_busy=0, o_retire=0, o_retire_cnt=0, o_error=0.
  - Wait counter and step-mode flag are cleared.
  - Reset overrides every other input, including mid-WAIT and during ERROR.
- States: IDLE, ACTIVE(k), WAIT(k), ERROR. All outputs are registered.
- IDLE:
  - If i_run=1, go to ACTIVE(0) with step_mode=0.
  - Else if i_step=1, go to ACTIVE(0) with step_mode=1.
  - i_flush is ignored.
- ACTIVE(k):
  - o_stage_en = 1<<k for exactly this one cycle.
  - If WAIT_MASK[k]=1, go to WAIT(k) and clear the wait counter.
  - Otherwise advance.
- WAIT(k):
  - o_stage_en=0, o_wait=1.
  - If i_stage_done[k]=1, advance.
  - Otherwise the counter increments; when the counter equals TIMEOUT-1 and done is still 0, go to ERROR.
  - Done asserted on the same cycle as ACTIVE(k) is ignored; a waited stage therefore takes at least 2 cycles.
- Advance from stage k:
  - If k < NUM_STAGES-1, go to ACTIVE(k+1).
  - If k = NUM_STAGES-1:
    - o_retire=1 on the next cycle.
    - o_retire_cnt increments, wrapping from 2^CNT_W-1 to 0.
    - Go to ACTIVE(0) if i_run=1 and step_mode=0; otherwise go to IDLE.
- Default timing: with immediate done, one instruction takes 7 cycles (5 ACTIVE + 2 WAIT). Back-to-back free-run gives a retire every 7 cycles.
- i_flush in ACTIVE or WAIT:
  - Next state is ACTIVE(0); no retire, no count change.
  - step_mode is preserved, so a flushed step re-executes.
  - Flush beats a simultaneous done and a simultaneous timeout.
- Deasserting i_run mid-instruction does not stop the sequencer; the current instruction completes, then it goes to IDLE.
- ERROR:
  - o_error=1 (sticky), o_stage_en=0, o_busy=0, o_stage_idx holds the timed-out stage.
  - i_clear_err goes to IDLE and clears o_error; o_retire_cnt is kept.
  - i_run, i_step and i_flush are ignored.
- Invariant: o_stage_en is either all zeros or exactly one-hot, and o_stage_idx equals the set bit whenever it is non-zero.

Test Plan:
1. Reset, i_run=1, done bits tied high → o_stage_en sequence 00001, wait, 00010, 00100, 01000, wait, 10000; o_retire pulses every 7 cycles; o_retire_cnt=3 after 21 cycles.
2. i_step pulse from IDLE, i_run=0 → exactly one instruction; o_retire_cnt=1; returns to IDLE with o_busy=0; a second step gives count=2.
3. In WAIT(3), hold i_stage_done[3]=0 for 15 cycles (TIMEOUT=16) → o_error=1, o_stage_idx=3; then i_clear_err → IDLE, o_error=0, count unchanged.
4. i_flush during WAIT(3), together with i_stage_done[3]=1 → next cycle o_stage_en=00001, no o_retire, count unchanged.
5. Preload o_retire_cnt to all-ones (CNT_W=4, count=15), retire one instruction → count=0, o_retire=1.
6. Assert i_reset during WAIT(0) and during ERROR → next cycle all outputs at reset values; NUM_STAGES=3, WAIT_MASK=3'b000 → a retire every 3 cycles.

Source files
------------

// File: rtl/stage_sequencer.sv
// Stage sequencer: drives one-hot stage enables for a multi-stage core from a
// single clock. Supports free-run and single-step operation, flush, per-stage
// completion handshakes, a WAIT watchdog and a retired-instruction counter.
module stage_sequencer #(
   parameter int                    NUM_STAGES = 5,
   parameter logic [NUM_STAGES-1:0] WAIT_MASK  = 5'b01001,
   parameter int                    TIMEOUT    = 16,
   parameter int                    CNT_W      = 32
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic                          i_run,
   input  logic                          i_step,
   input  logic                          i_flush,
   input  logic [NUM_STAGES-1:0]         i_stage_done,
   input  logic                          i_clear_err,
   output logic [NUM_STAGES-1:0]         o_stage_en,
   output logic [$clog2(NUM_STAGES)-1:0] o_stage_idx,
   output logic                          o_wait,
   output logic                          o_busy,
   output logic                          o_retire,
   output logic [CNT_W-1:0]              o_retire_cnt,
   output logic                          o_error
);

   localparam int IDX_W  = $clog2(NUM_STAGES);
   localparam int WCNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACTIVE,
      S_WAIT,
      S_ERROR
   } state_t;

   state_t                  state_q;
   logic [IDX_W-1:0]        stage_q;
   logic [WCNT_W-1:0]       wcnt_q;
   logic                    step_mode_q;
   logic [NUM_STAGES-1:0]   stage_en_q;
   logic                    wait_q;
   logic                    busy_q;
   logic                    retire_q;
   logic [CNT_W-1:0]        cnt_q;
   logic                    error_q;

   logic                    last_stage;
   logic [IDX_W-1:0]        next_idx;
   logic                    advance;
   logic                    timeout_hit;
   logic                    keep_running;

   function automatic logic [NUM_STAGES-1:0] one_hot(input logic [IDX_W-1:0] idx);
      logic [NUM_STAGES-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Decode of the current stage: whether it is the last one, whether it may
   // advance this cycle, and whether the watchdog expires on this WAIT cycle.
   assign last_stage   = (stage_q == IDX_W'(NUM_STAGES - 1));
   assign next_idx     = stage_q + IDX_W'(1);
   assign advance      = ((state_q == S_ACTIVE) && !WAIT_MASK[stage_q]) ||
                         ((state_q == S_WAIT) && i_stage_done[stage_q]);
   assign timeout_hit  = ((wcnt_q + WCNT_W'(1)) == WCNT_W'(TIMEOUT - 1));
   assign keep_running = i_run && !step_mode_q;

   // Sequencer FSM with all outputs registered alongside the state.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= S_IDLE;
         stage_q     <= '0;
         wcnt_q      <= '0;
         step_mode_q <= 1'b0;
         stage_en_q  <= '0;
         wait_q      <= 1'b0;
         busy_q      <= 1'b0;
         retire_q    <= 1'b0;
         cnt_q       <= '0;
         error_q     <= 1'b0;
      end else begin
         stage_en_q <= '0;
         retire_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (i_run || i_step) begin
                  step_mode_q <= !i_run;
                  state_q     <= S_ACTIVE;
                  stage_q     <= '0;
                  stage_en_q  <= one_hot('0);
                  busy_q      <= 1'b1;
                  wait_q      <= 1'b0;
               end
            end
            S_ACTIVE, S_WAIT: begin
               if (i_flush) begin
                  // Flush wins over done and timeout; step_mode is kept so a
                  // flushed single step runs again from fetch.
                  state_q    <= S_ACTIVE;
                  stage_q    <= '0;
                  stage_en_q <= one_hot('0);
                  wait_q     <= 1'b0;
                  wcnt_q     <= '0;
               end else if (advance) begin
                  wait_q <= 1'b0;
                  if (last_stage) begin
                     retire_q <= 1'b1;
                     cnt_q    <= cnt_q + CNT_W'(1);
                     if (keep_running) begin
                        state_q    <= S_ACTIVE;
                        stage_q    <= '0;
                        stage_en_q <= one_hot('0);
                     end else begin
                        state_q <= S_IDLE;
                        stage_q <= '0;
                        busy_q  <= 1'b0;
                     end
                  end else begin
                     state_q    <= S_ACTIVE;
                     stage_q    <= next_idx;
                     stage_en_q <= one_hot(next_idx);
                  end
               end else if (state_q == S_ACTIVE) begin
                  // Waited stage: done is only honoured from the next cycle on.
                  state_q <= S_WAIT;
                  wait_q  <= 1'b1;
                  wcnt_q  <= '0;
               end else if (timeout_hit) begin
                  state_q <= S_ERROR;
                  error_q <= 1'b1;
                  busy_q  <= 1'b0;
                  wait_q  <= 1'b0;
               end else begin
                  wcnt_q <= wcnt_q + WCNT_W'(1);
               end
            end
            S_ERROR: begin
               // stage_q keeps the timed-out stage until the error is cleared.
               if (i_clear_err) begin
                  state_q <= S_IDLE;
                  stage_q <= '0;
                  error_q <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               stage_q <= '0;
               busy_q  <= 1'b0;
               wait_q  <= 1'b0;
            end
         endcase
      end
   end

   assign o_stage_en   = stage_en_q;
   assign o_stage_idx  = stage_q;
   assign o_wait       = wait_q;
   assign o_busy       = busy_q;
   assign o_retire     = retire_q;
   assign o_retire_cnt = cnt_q;
   assign o_error      = error_q;

endmodule
